spike_window_readout: RTL
=========================

# spike_window_readout

Readout stage downstream of the output LIF layer. It integrates the per-class output spike vector over a fixed inference window, then runs a sequential argmax scan to produce the predicted digit. This replaces exposing a raw free-running spike count on the output pins with a framed, handshaked classification result.

## Interface
Parameters:
- NUM_CLASSES, 10, number of output neurons / classes
- COUNT_W, 8, width of each per-class spike counter (saturating)
- WINDOW_CYCLES, 64, accumulation window length in clock cycles (≥1)

Ports:
- clk_i  in  1  clock; one clock domain, all logic on the rising edge
- rst_ni  in  1  reset, asynchronous and active-low
- start_i  in  1  start an inference window; honoured only in IDLE
- spike_i  in  NUM_CLASSES  output-layer spike vector, bit k = class k
- busy_o  out  1  high in ACCUM, SCAN and DONE
- valid_o  out  1  one-cycle pulse, result outputs freshly updated
- digit_o  out  4  predicted class index
- max_count_o  out  COUNT_W  spike count of the winning class
- tie_o  out  1  another class equalled the winning count

## Operation
- States: IDLE, ACCUM, SCAN and DONE.
- IDLE:
  - start_i=1 clears all class counters and the window counter, then moves to ACCUM.
  - spike_i is ignored in IDLE, including on the start cycle.
- ACCUM:
  - On each edge, counter[k] += spike_i[k], saturating at 2^COUNT_W−1 (it holds and never wraps).
  - The window counter increments on each edge. After exactly WINDOW_CYCLES sampling edges, go to SCAN with the scan index set to 0.
- SCAN: one class per edge, index 0..NUM_CLASSES−1.
  - index 0: best=counter[0], best_idx=0, tie=0.
  - counter[i] > best: best=counter[i], best_idx=i, tie=0.
  - counter[i] == best (i>0): tie=1.
  - Comparison is strict, so the lowest index wins a tie.
  - On the last index, write the result registers (digit_o, max_count_o, tie_o) and go to DONE.
- DONE: valid_o=1 for this single cycle, then go to IDLE on the next edge.
- start_i is ignored outside IDLE. It is not queued.
- Result outputs hold their last value until the next DONE.
- Reset values, including on assertion mid-operation: state IDLE; all counters 0; busy_o=0, valid_o=0, digit_o=0, max_count_o=0, tie_o=0. No partial result is emitted.

## Timing
- Let e0 be the edge that samples start_i=1 in IDLE.
- spike_i is sampled at edges e1..eW, where W=WINDOW_CYCLES.
- The scan runs at edges e(W+1)..e(W+NUM_CLASSES). Result registers update at e(W+NUM_CLASSES).
- valid_o is high in the cycle after e(W+NUM_CLASSES).
- The block is back in IDLE after e(W+NUM_CLASSES+1). The earliest next start is sampled at e(W+NUM_CLASSES+2).
- busy_o goes high after e0 and low after e(W+NUM_CLASSES+1).
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package snn_pkg holds:
  - NUM_CLASSES and COUNT_W defaults
  - the readout state enum (IDLE/ACCUM/SCAN/DONE)
  - the digit index width constant (4)
- Sub-module sat_counter: one COUNT_W saturating counter with synchronous clear and increment enable, plus async active-low reset.
  - Instantiate it NUM_CLASSES times in a generate loop.
- The FSM, window counter, scan index and argmax registers live in the top module.

## Test plan
- Reset mid-ACCUM: assert rst_ni=0 at edge e10. Expect busy_o=0, digit_o=0, max_count_o=0, tie_o=0, and no valid_o pulse.
- Single active class: W=64, spike_i[7]=1 every cycle, other bits 0.
  - valid_o pulses exactly at the cycle after e74.
  - digit_o=7, max_count_o=64, tie_o=0.
- Tie: classes 3 and 5 each spike 20 times, the others fewer. Expect digit_o=3, max_count_o=20, tie_o=1.
- Silent window: spike_i=0 throughout. Expect digit_o=0, max_count_o=0, tie_o=1.
- Saturation: WINDOW_CYCLES=300, COUNT_W=8, spike_i[2]=1 constantly. Expect max_count_o=255, digit_o=2, no wrap.
- Start handling:
  - start_i held high through ACCUM and DONE produces exactly one result.
  - spike_i activity on the e0 cycle is not counted (spike_i[1]=1 only at e0 gives max_count_o=0 for class 1).

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN output readout path.
package snn_pkg;

  localparam int unsigned NUM_CLASSES_DEF = 10;
  localparam int unsigned COUNT_W_DEF     = 8;
  localparam int unsigned DIGIT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } readout_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/spike_window_readout.sv
// Integrates output-layer spikes over a fixed window, then scans the class
// counters one per cycle to report the argmax digit with a one-cycle valid.
module spike_window_readout
  import snn_pkg::*;
#(
  parameter int unsigned NUM_CLASSES   = NUM_CLASSES_DEF,
  parameter int unsigned COUNT_W       = COUNT_W_DEF,
  parameter int unsigned WINDOW_CYCLES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [NUM_CLASSES-1:0] spike_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [DIGIT_W-1:0]     digit_o,
  output logic [COUNT_W-1:0]     max_count_o,
  output logic                   tie_o
);

  localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [DIGIT_W-1:0] IDX_LAST = DIGIT_W'(NUM_CLASSES - 1);

  readout_state_e state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [DIGIT_W-1:0] idx_q, idx_d;
  logic [COUNT_W-1:0] best_q, best_d;
  logic [DIGIT_W-1:0] best_idx_q, best_idx_d;
  logic               scan_tie_q, scan_tie_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [COUNT_W-1:0] max_q, max_d;
  logic               tie_q, tie_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic               start_fire;
  logic               accum_en;
  logic [COUNT_W-1:0] cnt [NUM_CLASSES];
  logic [COUNT_W-1:0] cur;

  assign start_fire = (state_q == ST_IDLE) && start_i;
  assign accum_en   = (state_q == ST_ACCUM);

  // One saturating counter per class; cleared on the accepted start.
  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cnt
    sat_counter #(.WIDTH(COUNT_W)) u_cnt (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .clr   (start_fire),
      .inc   (accum_en & spike_i[k]),
      .count (cnt[k])
    );
  end

  // Counter currently addressed by the scan index.
  always_comb begin
    cur = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (idx_q == DIGIT_W'(k)) cur = cnt[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      scan_tie_q <= 1'b0;
      digit_q    <= '0;
      max_q      <= '0;
      tie_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      scan_tie_q <= scan_tie_d;
      digit_q    <= digit_d;
      max_q      <= max_d;
      tie_q      <= tie_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    scan_tie_d = scan_tie_q;
    digit_d    = digit_q;
    max_d      = max_q;
    tie_d      = tie_q;
    valid_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ACCUM;
          win_d   = '0;
        end
      end
      ST_ACCUM: begin
        win_d = win_q + WIN_W'(1);
        if (win_q == WIN_LAST) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        // Strict compare keeps the lowest index on a tie.
        if (idx_q == '0) begin
          best_d     = cur;
          best_idx_d = '0;
          scan_tie_d = 1'b0;
        end else if (cur > best_q) begin
          best_d     = cur;
          best_idx_d = idx_q;
          scan_tie_d = 1'b0;
        end else if (cur == best_q) begin
          scan_tie_d = 1'b1;
        end
        idx_d = idx_q + DIGIT_W'(1);
        if (idx_q == IDX_LAST) begin
          digit_d = best_idx_d;
          max_d   = best_d;
          tie_d   = scan_tie_d;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign busy_o      = busy_q;
  assign valid_o     = valid_q;
  assign digit_o     = digit_q;
  assign max_count_o = max_q;
  assign tie_o       = tie_q;

endmodule
